esp_at_sequencer: RTL

//  Boot-time AT-command sequencer and stream arbiter between host UART byte streams and PMOD ESP32 UART byte streams.

---
 rtl/esp_at_pkg.sv | 75 +++++++
 rtl/esp_cmd_rom.sv | 16 +
 rtl/esp_at_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/esp_at_pkg.sv
// Shared types and constants for the ESP32 AT-command boot sequencer:
// FSM states, reply patterns, the command ROM image and command offsets.
package esp_at_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_RSP,
      DONE,
      FAIL
   } state_t;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   localparam int OK_LEN  = 4;
   localparam int ERR_LEN = 5;

   // Commands are stored back to back, each terminated by a 0x00 byte.
   localparam int ROM_LEN = 40;
   localparam int ROM_AW  = 6;

   localparam logic [ROM_LEN*8-1:0] ROM_IMAGE = {
      "AT",          CHAR_CR, CHAR_LF, 8'h00,
      "ATE0",        CHAR_CR, CHAR_LF, 8'h00,
      "AT+CWMODE=1", CHAR_CR, CHAR_LF, 8'h00,
      "AT+CIPMUX=0", CHAR_CR, CHAR_LF, 8'h00
   };

   // First ROM address of each command.
   function automatic logic [ROM_AW-1:0] cmd_offset(input int idx);
      case (idx)
         1:       return 6'd5;
         2:       return 6'd12;
         3:       return 6'd26;
         default: return 6'd0;
      endcase
   endfunction

   // Character expected at each position of "OK\r\n".
   function automatic logic [7:0] ok_char(input logic [2:0] i);
      case (i)
         3'd0:    return "O";
         3'd1:    return "K";
         3'd2:    return CHAR_CR;
         3'd3:    return CHAR_LF;
         default: return 8'h00;
      endcase
   endfunction

   // Character expected at each position of "ERROR".
   function automatic logic [7:0] err_char(input logic [2:0] i);
      case (i)
         3'd0:    return "E";
         3'd1:    return "R";
         3'd2:    return "R";
         3'd3:    return "O";
         3'd4:    return "R";
         default: return 8'h00;
      endcase
   endfunction

   // One matcher step: advance on a hit, otherwise restart (possibly on this byte).
   function automatic logic [2:0] match_next(input logic [2:0] idx,
                                             input logic [7:0] rx_byte,
                                             input logic [7:0] want,
                                             input logic [7:0] first);
      if (rx_byte == want)
         return idx + 3'd1;
      else if (rx_byte == first)
         return 3'd1;
      return 3'd0;
   endfunction

endpackage

// File: rtl/esp_cmd_rom.sv
// Combinational lookup of one byte of the AT-command ROM image.
module esp_cmd_rom
   import esp_at_pkg::*;
(
   input  logic [ROM_AW-1:0] addr,
   output logic [7:0]        data
);

   // Byte 0 is the leftmost character of the packed image; out-of-range reads return 0x00.
   always_comb begin
      data = 8'h00;
      if (addr < ROM_AW'(ROM_LEN))
         data = ROM_IMAGE[(ROM_LEN - 1 - int'(addr)) * 8 +: 8];
   end

endmodule

// File: rtl/esp_at_sequencer.sv
// Boot-time AT-command sequencer: streams the ROM commands to the ESP32,
// checks each reply for OK/ERROR with timeout and retry, and otherwise
// passes host bytes straight through. ESP RX is always echoed to the host.
module esp_at_sequencer
   import esp_at_pkg::*;
#(
   parameter  int NUM_CMDS    = 4,
   parameter  int TIMEOUT_CYC = 100_000_000,
   parameter  int MAX_RETRY   = 2,
   localparam int CW          = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [CW-1:0] fail_cmd,
   input  logic [7:0]    host_rx_data,
   input  logic          host_rx_valid,
   output logic          host_rx_ready,
   output logic [7:0]    esp_tx_data,
   output logic          esp_tx_valid,
   input  logic          esp_tx_ready,
   input  logic [7:0]    esp_rx_data,
   input  logic          esp_rx_valid,
   output logic          esp_rx_ready,
   output logic [7:0]    host_tx_data,
   output logic          host_tx_valid,
   input  logic          host_tx_ready
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   state_t            state;
   logic [ROM_AW-1:0] ptr;
   logic [ROM_AW-1:0] ptr_nxt;
   logic [CW-1:0]     cmd_idx;
   logic [RW-1:0]     retry;
   logic [TW-1:0]     tmo_cnt;
   logic [2:0]        ok_idx;
   logic [2:0]        err_idx;
   logic              start_pend;

   logic [7:0]        rom_cur;
   logic [7:0]        rom_nxt;
   logic              passthru;
   logic              esp_tx_fire;
   logic              rx_fire;
   logic [2:0]        ok_step;
   logic [2:0]        err_step;
   logic              ok_hit;
   logic              err_hit;
   logic              tmo_hit;
   logic              last_cmd;
   logic              can_launch;

   // Current byte drives the ESP TX; the following byte tells us when the command ends.
   assign ptr_nxt = ptr + ROM_AW'(1);

   esp_cmd_rom u_rom_cur (
      .addr (ptr),
      .data (rom_cur)
   );

   esp_cmd_rom u_rom_nxt (
      .addr (ptr_nxt),
      .data (rom_nxt)
   );

   // Host owns the ESP TX path whenever no sequence is running.
   assign passthru      = (state == IDLE) || (state == DONE) || (state == FAIL);
   assign host_rx_ready = passthru ? esp_tx_ready : 1'b0;
   assign esp_tx_valid  = passthru ? host_rx_valid : (state == SEND);
   assign esp_tx_data   = passthru ? host_rx_data : rom_cur;

   // ESP RX is echoed to the host unconditionally, so host backpressure stalls the ESP.
   assign host_tx_data  = esp_rx_data;
   assign host_tx_valid = esp_rx_valid;
   assign esp_rx_ready  = host_tx_ready;

   // Reply matching and timeout decisions for the current cycle.
   assign esp_tx_fire = esp_tx_valid && esp_tx_ready;
   assign rx_fire     = esp_rx_valid && host_tx_ready;
   assign ok_step     = match_next(ok_idx, esp_rx_data, ok_char(ok_idx), ok_char(3'd0));
   assign err_step    = match_next(err_idx, esp_rx_data, err_char(err_idx), err_char(3'd0));
   assign ok_hit      = rx_fire && (ok_step == 3'(OK_LEN));
   assign err_hit     = rx_fire && (err_step == 3'(ERR_LEN));
   assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign last_cmd    = (cmd_idx == CW'(NUM_CMDS - 1));
   assign can_launch  = !host_rx_valid || esp_tx_ready;

   // Sequencer FSM with registered status outputs; a start is held pending until no host byte is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         fail_cmd   <= '0;
         ptr        <= '0;
         cmd_idx    <= '0;
         retry      <= '0;
         tmo_cnt    <= '0;
         ok_idx     <= '0;
         err_idx    <= '0;
         start_pend <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE, FAIL: begin
               if (start || start_pend) begin
                  done     <= 1'b0;
                  error    <= 1'b0;
                  fail_cmd <= '0;
                  if (can_launch) begin
                     state      <= SEND;
                     busy       <= 1'b1;
                     cmd_idx    <= '0;
                     retry      <= '0;
                     ptr        <= cmd_offset(0);
                     start_pend <= 1'b0;
                  end else begin
                     start_pend <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (esp_tx_fire) begin
                  ptr <= ptr_nxt;
                  if (rom_nxt == 8'h00) begin
                     state   <= WAIT_RSP;
                     tmo_cnt <= '0;
                     ok_idx  <= '0;
                     err_idx <= '0;
                  end
               end
            end
            WAIT_RSP: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (rx_fire) begin
                  ok_idx  <= ok_step;
                  err_idx <= err_step;
               end
               if (ok_hit) begin
                  retry <= '0;
                  if (last_cmd) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     cmd_idx <= cmd_idx + CW'(1);
                     ptr     <= cmd_offset(int'(cmd_idx) + 1);
                     state   <= SEND;
                  end
               end else if (err_hit || tmo_hit) begin
                  if (retry < RW'(MAX_RETRY)) begin
                     retry <= retry + RW'(1);
                     ptr   <= cmd_offset(int'(cmd_idx));
                     state <= SEND;
                  end else begin
                     state    <= FAIL;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                     fail_cmd <= cmd_idx;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
